// File: rtl/clk0_res_monitor_6502_pkg.sv
// Shared definitions for the 6502 clock/reset monitor.
// Contents: reset-sequence state enum, counter widths, saturating increment helper.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    WAIT_RES = 2'd0,
    IN_RES   = 2'd1,
    RUN      = 2'd2
  } mon_state_e;

  localparam int RES_CNT_W = 8;
  localparam int CYC_CNT_W = 32;

  // Reset-pulse rise counter increment that sticks at all-ones.
  function automatic logic [RES_CNT_W-1:0] sat_inc_res(input logic [RES_CNT_W-1:0] v);
    if (v == {RES_CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + RES_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/clk0_res_monitor_6502_if.sv
// Bus bundle between the clk0/res stimulus and the monitor.
// master: drives res/clk0, observes the monitor results.
// slave : the monitor; samples res/clk0, drives strobes, measurements and flags.
interface clk0_res_monitor_6502_if
  import clk_mon_pkg::*;
#(
  parameter int unsigned LEN_W = 8
);
  logic                 res;
  logic                 clk0;
  logic                 clk0_rise;
  logic                 clk0_fall;
  logic [LEN_W-1:0]     half_len;
  logic                 period_err;
  logic [RES_CNT_W-1:0] res_cycles;
  logic                 res_done;
  logic                 res_short_err;
  logic                 run;
  logic [CYC_CNT_W-1:0] cycle_count;

  modport master (
    output res, clk0,
    input  clk0_rise, clk0_fall, half_len, period_err, res_cycles,
           res_done, res_short_err, run, cycle_count
  );

  modport slave (
    input  res, clk0,
    output clk0_rise, clk0_fall, half_len, period_err, res_cycles,
           res_done, res_short_err, run, cycle_count
  );
endinterface

// File: rtl/clk0_res_monitor_6502_edge_det.sv
// clk0 edge detector.
// Ports: eclk/ereset (clock, sync active-high reset), clk0_i (level in),
//        rise_now_o/fall_now_o (edge seen in the current sample, combinational),
//        rise_o/fall_o (registered one-cycle strobes, one cycle after the edge sample).
// The primed flag suppresses a false edge against the reset value of the sample register.
module clk_edge_det (
  input  logic eclk,
  input  logic ereset,
  input  logic clk0_i,
  output logic rise_now_o,
  output logic fall_now_o,
  output logic rise_o,
  output logic fall_o
);
  logic clk0_q;
  logic primed_q;
  logic rise_q;
  logic fall_q;

  assign rise_now_o = primed_q &  clk0_i & ~clk0_q;
  assign fall_now_o = primed_q & ~clk0_i &  clk0_q;

  // Sample register, primed gate and strobe registers.
  always_ff @(posedge eclk) begin
    if (ereset) begin
      clk0_q   <= 1'b0;
      primed_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      clk0_q   <= clk0_i;
      primed_q <= 1'b1;
      rise_q   <= rise_now_o;
      fall_q   <= fall_now_o;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/clk0_res_monitor_6502.sv
// 6502 clk0/res receiving-end monitor.
// Ports: eclk (system clock), ereset (sync active-high reset),
//        mon (slave modport): res/clk0 in; clk0_rise/clk0_fall strobes, half_len,
//        period_err, res_cycles, res_done, res_short_err, run, cycle_count out.
// half_len is the distance in eclk cycles between two successive detected clk0 edges.
module clk0_res_monitor_6502
  import clk_mon_pkg::*;
#(
  parameter int unsigned HALFCYCLE      = 4,
  parameter int unsigned MIN_RES_CYCLES = 2,
  parameter int unsigned LEN_W          = 8
) (
  input  logic eclk,
  input  logic ereset,
  clk0_res_monitor_6502_if.slave mon
);
  logic rise_now_s, fall_now_s, edge_now_s;
  logic rise_strobe_s, fall_strobe_s;

  logic [LEN_W-1:0]     hcnt_q, hcnt_d;
  logic                 meas_ok_q, meas_ok_d;
  logic [LEN_W-1:0]     half_len_q, half_len_d;
  logic                 period_err_q, period_err_d;
  mon_state_e           state_q, state_d;
  logic [RES_CNT_W-1:0] res_cycles_q, res_cycles_d;
  logic [RES_CNT_W-1:0] rc_rise_s;
  logic                 res_done_q, res_done_d;
  logic                 res_short_err_q, res_short_err_d;
  logic                 run_q, run_d;
  logic [CYC_CNT_W-1:0] cycle_count_q, cycle_count_d;

  clk_edge_det u_edge (
    .eclk       (eclk),
    .ereset     (ereset),
    .clk0_i     (mon.clk0),
    .rise_now_o (rise_now_s),
    .fall_now_o (fall_now_s),
    .rise_o     (rise_strobe_s),
    .fall_o     (fall_strobe_s)
  );

  assign edge_now_s = rise_now_s | fall_now_s;

  // Next-state logic for half-period measurement and the reset-sequence FSM.
  always_comb begin
    hcnt_d          = hcnt_q;
    meas_ok_d       = meas_ok_q;
    half_len_d      = half_len_q;
    period_err_d    = period_err_q;
    state_d         = state_q;
    res_cycles_d    = res_cycles_q;
    res_done_d      = 1'b0;
    res_short_err_d = res_short_err_q;
    cycle_count_d   = cycle_count_q;
    rc_rise_s       = rise_now_s ? sat_inc_res(res_cycles_q) : res_cycles_q;

    // hcnt reaches the half-period length in the cycle the next edge is seen.
    if (edge_now_s) begin
      hcnt_d    = LEN_W'(1);
      meas_ok_d = 1'b1;
      if (meas_ok_q) begin
        half_len_d = hcnt_q;
        if (hcnt_q != LEN_W'(HALFCYCLE)) begin
          period_err_d = 1'b1;
        end else begin
          period_err_d = period_err_q;
        end
      end else begin
        half_len_d = half_len_q;
      end
    end else if (hcnt_q != {LEN_W{1'b1}}) begin
      hcnt_d = hcnt_q + LEN_W'(1);
    end else begin
      hcnt_d = hcnt_q;
    end

    case (state_q)
      WAIT_RES: begin
        if (!mon.res) begin
          state_d      = IN_RES;
          res_cycles_d = {RES_CNT_W{1'b0}};
        end else begin
          state_d = WAIT_RES;
        end
      end
      IN_RES: begin
        // A rise in the release sample still counts before the length check.
        res_cycles_d = rc_rise_s;
        if (mon.res) begin
          if (rc_rise_s >= RES_CNT_W'(MIN_RES_CYCLES)) begin
            state_d       = RUN;
            res_done_d    = 1'b1;
            cycle_count_d = {CYC_CNT_W{1'b0}};
          end else begin
            state_d         = WAIT_RES;
            res_short_err_d = 1'b1;
          end
        end else begin
          state_d = IN_RES;
        end
      end
      RUN: begin
        if (!mon.res) begin
          // A rise coincident with re-assertion belongs to the new pulse.
          state_d      = IN_RES;
          res_cycles_d = rise_now_s ? RES_CNT_W'(1) : {RES_CNT_W{1'b0}};
        end else if (rise_now_s) begin
          cycle_count_d = cycle_count_q + CYC_CNT_W'(1);
        end else begin
          cycle_count_d = cycle_count_q;
        end
      end
      default: begin
        state_d = WAIT_RES;
      end
    endcase

    run_d = (state_d == RUN);
  end

  // State and output registers.
  always_ff @(posedge eclk) begin
    if (ereset) begin
      hcnt_q          <= {LEN_W{1'b0}};
      meas_ok_q       <= 1'b0;
      half_len_q      <= {LEN_W{1'b0}};
      period_err_q    <= 1'b0;
      state_q         <= WAIT_RES;
      res_cycles_q    <= {RES_CNT_W{1'b0}};
      res_done_q      <= 1'b0;
      res_short_err_q <= 1'b0;
      run_q           <= 1'b0;
      cycle_count_q   <= {CYC_CNT_W{1'b0}};
    end else begin
      hcnt_q          <= hcnt_d;
      meas_ok_q       <= meas_ok_d;
      half_len_q      <= half_len_d;
      period_err_q    <= period_err_d;
      state_q         <= state_d;
      res_cycles_q    <= res_cycles_d;
      res_done_q      <= res_done_d;
      res_short_err_q <= res_short_err_d;
      run_q           <= run_d;
      cycle_count_q   <= cycle_count_d;
    end
  end

  assign mon.clk0_rise     = rise_strobe_s;
  assign mon.clk0_fall     = fall_strobe_s;
  assign mon.half_len      = half_len_q;
  assign mon.period_err    = period_err_q;
  assign mon.res_cycles    = res_cycles_q;
  assign mon.res_done      = res_done_q;
  assign mon.res_short_err = res_short_err_q;
  assign mon.run           = run_q;
  assign mon.cycle_count   = cycle_count_q;
endmodule
